// File: rtl/vec_pkg.sv
// Shared definitions for the vector unpacker: default widths, FSM state
// encoding and the job length normalisation rule.
package vec_pkg;

  localparam int V_DEF  = 128;
  localparam int N_DEF  = 32;
  localparam int LANES  = V_DEF / N_DEF;
  localparam int LANE_W = 2;
  localparam int CNT_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // A count of zero or anything above the lane total means "all lanes".
  function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
    return (c == '0 || c > CNT_W'(LANES)) ? CNT_W'(LANES) : c;
  endfunction

endpackage

// File: rtl/vector_unpack_if.sv
// Job-request and scalar-stream handshake bundle for vector_unpack.
// slave = the unpacker, master = whoever issues jobs and consumes scalars.
interface vector_unpack_if
  import vec_pkg::*;
#(
  parameter int V = V_DEF,
  parameter int N = N_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [V-1:0]      vector_input;
  logic [LANE_W-1:0] imm;
  logic [CNT_W-1:0]  count;
  logic              dir;

  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      dst;
  logic [LANE_W-1:0] lane_idx;
  logic              last;

  modport slave (
    input  in_valid, vector_input, imm, count, dir, out_ready,
    output in_ready, out_valid, dst, lane_idx, last
  );

  modport master (
    output in_valid, vector_input, imm, count, dir, out_ready,
    input  in_ready, out_valid, dst, lane_idx, last
  );

endinterface

// File: rtl/vector_lane_select.sv
// Purely combinational lane extractor: returns N-bit lane 'lane' of 'vector'.
module vector_lane_select
  import vec_pkg::*;
#(
  parameter int V = V_DEF,
  parameter int N = N_DEF
) (
  input  logic [V-1:0]      vector,
  input  logic [LANE_W-1:0] lane,
  output logic [N-1:0]      scalar
);

  assign scalar = vector[int'(lane)*N +: N];

endmodule

// File: rtl/vector_unpack.sv
// Streams selected N-bit lanes of a captured V-bit vector, one per handshake,
// with back-to-back job chaining. Define VEC_UNPACK_REVERSE_EN to honour 'dir'.
module vector_unpack
  import vec_pkg::*;
#(
  parameter int V = V_DEF,
  parameter int N = N_DEF
) (
  input logic            clk,
  input logic            rst_n,
  vector_unpack_if.slave bus
);

  state_t            state_q, state_d;
  logic [V-1:0]      vec_q;
  logic [LANE_W-1:0] ptr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [LANE_W-1:0] step;
  logic              out_valid_w, in_ready_w, last_w;
  logic              accept, fire;

  assign last_w = (rem_q == CNT_W'(1));
  assign fire   = out_valid_w & bus.out_ready;
  assign accept = bus.in_valid & in_ready_w;

`ifdef VEC_UNPACK_REVERSE_EN
  logic dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dir_q <= 1'b0;
    else if (accept) dir_q <= bus.dir;
  end

  // Stepping by 3 in a 2-bit pointer is a modulo-4 decrement.
  assign step = dir_q ? LANE_W'(3) : LANE_W'(1);
`else
  logic dir_unused;
  assign dir_unused = bus.dir;
  assign step       = LANE_W'(1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (fire && last_w && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready also opens on the final handshake so a new job chains without a bubble.
  always_comb begin
    out_valid_w = (state_q == STREAM);
    in_ready_w  = (state_q == IDLE) || (out_valid_w && bus.out_ready && last_w);
  end

  // NOTE: the captured vector is a plain register rather than a memory, and it
  // is reset on purpose: dst is read straight from it and must be zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      ptr_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      vec_q <= bus.vector_input;
      ptr_q <= bus.imm;
      rem_q <= eff_count(bus.count);
    end else if (fire) begin
      ptr_q <= ptr_q + step;
      rem_q <= rem_q - CNT_W'(1);
    end
  end

  vector_lane_select #(.V(V), .N(N)) u_lane_select (
    .vector (vec_q),
    .lane   (ptr_q),
    .scalar (bus.dst)
  );

  assign bus.out_valid = out_valid_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.lane_idx  = ptr_q;
  assign bus.last      = last_w;

endmodule

// File: tb/tb_vector_unpack.sv
// Self-checking bench for vector_unpack: a queue-based job model checked every
// cycle, plus directed scenarios with literal expected lane sequences.
module tb_vector_unpack;
  import vec_pkg::*;

  localparam logic [127:0] VEC = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [31:0] LA = 32'hAAAAAAAA;
  localparam logic [31:0] LB = 32'hBBBBBBBB;
  localparam logic [31:0] LC = 32'hCCCCCCCC;
  localparam logic [31:0] LD = 32'hDDDDDDDD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_unpack_if #(.V(V_DEF), .N(N_DEF)) bus ();

  vector_unpack #(.V(V_DEF), .N(N_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
    int          cyc;
  } seen_t;

  beat_t exp_q[$];
  seen_t seen[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    accepted = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Model: a job expands into its list of (lane, data, last) beats.
  function automatic void push_job(input logic [127:0] v, input logic [1:0] imm,
                                   input logic [2:0] cnt, input logic d);
    int  n;
    bit  rev;
    n = (cnt == 0 || cnt > 4) ? 4 : int'(cnt);
`ifdef VEC_UNPACK_REVERSE_EN
    rev = d;
`else
    rev = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      beat_t b;
      int    lane;
      lane   = ((int'(imm) + (rev ? -i : i)) % 4 + 4) % 4;
      b.lane = 2'(lane);
      b.data = v[lane*32 +: 32];
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: outputs checked on the falling edge, model advanced to
  // what the next rising edge will do.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      accepted = 1'b0;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_dst", 64'(bus.dst), 64'd0);
    end else begin
      bit exp_ir;
      exp_ir = (exp_q.size() == 0) || (bus.out_ready && exp_q[0].last);
      check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("dst", 64'(bus.dst), 64'(exp_q[0].data));
        check("lane_idx", 64'(bus.lane_idx), 64'(exp_q[0].lane));
        check("last", 64'(bus.last), 64'(exp_q[0].last));
        if (bus.out_ready) begin
          seen.push_back('{bus.dst, bus.lane_idx, bus.last, cyc});
          void'(exp_q.pop_front());
        end
      end
      accepted = bus.in_valid && exp_ir;
      if (accepted) push_job(bus.vector_input, bus.imm, bus.count, bus.dir);
    end
  end

  task automatic send(input logic [1:0] imm, input logic [2:0] cnt, input logic d);
    bus.vector_input = VEC;
    bus.imm          = imm;
    bus.count        = cnt;
    bus.dir          = d;
    bus.in_valid     = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (accepted) begin
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    timeout_fail("accept");
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        #1;
        return;
      end
    end
    timeout_fail("drain");
  endtask

  task automatic expect_seen(input string tag, input int n, input logic [31:0] d[4],
                             input logic [1:0] l[4], input logic [3:0] lastmask);
    check({tag, "_beats"}, 64'(seen.size()), 64'(n));
    for (int i = 0; i < n && i < seen.size(); i++) begin
      check($sformatf("%s_dst%0d", tag, i), 64'(seen[i].data), 64'(d[i]));
      check($sformatf("%s_lane%0d", tag, i), 64'(seen[i].lane), 64'(l[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(seen[i].last), 64'(lastmask[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.vector_input = '0;
    bus.imm          = '0;
    bus.count        = '0;
    bus.dir          = 1'b0;
    bus.out_ready    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_lane_idx", 64'(bus.lane_idx), 64'd0);
    check("reset_last", 64'(bus.last), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Full ascending job, consumer always ready
    seen.delete();
    send(2'd0, 3'd4, 1'b0);
    wait_idle();
    expect_seen("asc4", 4, '{LA, LB, LC, LD}, '{2'd0, 2'd1, 2'd2, 2'd3}, 4'b1000);
    if (seen.size() == 4)
      check("asc4_back_to_back", 64'(seen[3].cyc - seen[0].cyc), 64'd3);

    // Wrap from lane 3 to lane 0
    seen.delete();
    send(2'd3, 3'd2, 1'b0);
    wait_idle();
    expect_seen("wrap", 2, '{LD, LA, 32'd0, 32'd0}, '{2'd3, 2'd0, 2'd0, 2'd0}, 4'b0010);

    // Consumer stalls three cycles on the second beat
    seen.delete();
    send(2'd0, 3'd4, 1'b0);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle();
    expect_seen("stall", 4, '{LA, LB, LC, LD}, '{2'd0, 2'd1, 2'd2, 2'd3}, 4'b1000);
    if (seen.size() == 4)
      check("stall_gap", 64'(seen[1].cyc - seen[0].cyc), 64'd4);

    // New job accepted on the final handshake of the previous one
    seen.delete();
    send(2'd0, 3'd2, 1'b0);
    @(posedge clk);
    #1;
    send(2'd2, 3'd1, 1'b0);
    wait_idle();
    expect_seen("chain", 3, '{LA, LB, LC, 32'd0}, '{2'd0, 2'd1, 2'd2, 2'd0}, 4'b0110);
    if (seen.size() == 3)
      check("chain_no_bubble", 64'(seen[2].cyc - seen[1].cyc), 64'd1);

    // Count above four behaves as four
    seen.delete();
    send(2'd2, 3'd7, 1'b0);
    wait_idle();
    expect_seen("cnt7", 4, '{LC, LD, LA, LB}, '{2'd2, 2'd3, 2'd0, 2'd1}, 4'b1000);

    // Reset mid-job after two beats
    seen.delete();
    send(2'd0, 3'd4, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_dst", 64'(bus.dst), 64'd0);
    check("midrst_lane_idx", 64'(bus.lane_idx), 64'd0);
    check("midrst_last", 64'(bus.last), 64'd0);
    check("midrst_beats", 64'(seen.size()), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    seen.delete();
    send(2'd1, 3'd0, 1'b0);
    wait_idle();
    expect_seen("cnt0", 4, '{LB, LC, LD, LA}, '{2'd1, 2'd2, 2'd3, 2'd0}, 4'b1000);

    // Direction request: honoured only in the reverse-enabled build
    seen.delete();
    send(2'd1, 3'd3, 1'b1);
    wait_idle();
`ifdef VEC_UNPACK_REVERSE_EN
    expect_seen("dir", 3, '{LB, LA, LD, 32'd0}, '{2'd1, 2'd0, 2'd3, 2'd0}, 4'b0100);
`else
    expect_seen("dir", 3, '{LB, LC, LD, 32'd0}, '{2'd1, 2'd2, 2'd3, 2'd0}, 4'b0100);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
